// File: rtl/control_pipe.sv
// Control-word carrier for the 16-bit MIPS-style pipeline: ID/EX, EX/MEM, MEM/WB
// control registers plus load-use stall, branch/jump flush and EX forwarding selects.
module control_pipe #(
    parameter int REG_AW = 4,
    parameter int CW     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW-1:0]     id_ctrl,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_ne,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              jump_take,
    output logic              branch_take,
    output logic              ex_alu_src,
    output logic              ex_reg_dest,
    output logic [2:0]        ex_alu_op,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_mem_write,
    output logic              mem_mem_read,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_dst
);
    // ID-side decode; an invalid slot behaves as an all-zero word
    logic [CW-1:0]     idw;
    logic              id_jump, id_uses_rt, stall;
    logic [REG_AW-1:0] id_dst;

    // ID/EX
    logic              ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_mem_read, ex_branch;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst;

    // EX/MEM
    logic              mem_reg_write, mem_mem_to_reg, mem_branch;
    logic [REG_AW-1:0] mem_dst;

    assign idw        = id_valid ? id_ctrl : '0;
    assign id_jump    = idw[10];
    assign id_uses_rt = idw[0] | idw[7] | idw[1];
    assign id_dst     = idw[0] ? id_rd : id_rt;

    assign stall = ex_mem_read && (ex_dst != '0) && id_valid && !id_jump &&
                   ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    // A taken branch outranks the stall: the stalled instruction is squashed anyway
    assign branch_take = mem_branch & mem_ne;
    assign jump_take   = id_valid & id_jump & ~stall & ~branch_take;
    assign pc_write    = branch_take | ~stall;
    assign ifid_write  = branch_take | ~stall;
    assign ifid_flush  = branch_take | jump_take;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rs))
            fwd_a = 2'b10;
        else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs))
            fwd_a = 2'b01;
        if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rt))
            fwd_b = 2'b10;
        else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt))
            fwd_b = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg_write   <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_alu_op      <= 3'b000;
            ex_mem_to_reg  <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_branch      <= 1'b0;
            ex_reg_dest    <= 1'b0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_dst         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_branch     <= 1'b0;
            mem_dst        <= '0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_dst         <= '0;
        end else begin
            if (branch_take || stall) begin
                ex_reg_write  <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_alu_op     <= 3'b000;
                ex_mem_to_reg <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_branch     <= 1'b0;
                ex_reg_dest   <= 1'b0;
                ex_rs         <= '0;
                ex_rt         <= '0;
                ex_dst        <= '0;
            end else begin
                // A jump travels on as a no-op: it never writes a register or memory
                ex_reg_write  <= idw[9] & ~id_jump;
                ex_alu_src    <= idw[8];
                ex_mem_write  <= idw[7] & ~id_jump;
                ex_alu_op     <= idw[6:4];
                ex_mem_to_reg <= idw[3];
                ex_mem_read   <= idw[2];
                ex_branch     <= idw[1];
                ex_reg_dest   <= idw[0];
                ex_rs         <= id_rs;
                ex_rt         <= id_rt;
                ex_dst        <= id_dst;
            end

            if (branch_take) begin
                mem_reg_write  <= 1'b0;
                mem_mem_write  <= 1'b0;
                mem_mem_to_reg <= 1'b0;
                mem_mem_read   <= 1'b0;
                mem_branch     <= 1'b0;
                mem_dst        <= '0;
            end else begin
                mem_reg_write  <= ex_reg_write;
                mem_mem_write  <= ex_mem_write;
                mem_mem_to_reg <= ex_mem_to_reg;
                mem_mem_read   <= ex_mem_read;
                mem_branch     <= ex_branch;
                mem_dst        <= ex_dst;
            end

            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_dst        <= mem_dst;
        end
    end
endmodule

// File: tb/tb_control_pipe.sv
// Directed-vector bench for control_pipe: forwarding, load-use stall, branch/jump
// flush and async reset, all against hand-computed expectations.
module tb_control_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] id_ctrl = '0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        mem_ne = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, jump_take, branch_take;
    logic        ex_alu_src, ex_reg_dest;
    logic [2:0]  ex_alu_op;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_mem_write, mem_mem_read, wb_reg_write, wb_mem_to_reg;
    logic [3:0]  wb_dst;

    int nvec = 0;
    int nerr = 0;

    localparam logic [10:0] ADD = 11'h201, SUB = 11'h211, AND = 11'h221,
                            LW = 11'h30C, BNE = 11'h052, JMP = 11'h400;

    control_pipe #(.REG_AW(4), .CW(11)) dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_ne(mem_ne),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .jump_take(jump_take), .branch_take(branch_take),
        .ex_alu_src(ex_alu_src), .ex_reg_dest(ex_reg_dest), .ex_alu_op(ex_alu_op),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] c, input logic v,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
        id_ctrl = c; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive('0, 1'b0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ex_alu_src"}, int'(ex_alu_src), 0);
        chk({tag, "_ex_reg_dest"}, int'(ex_reg_dest), 0);
        chk({tag, "_ex_alu_op"}, int'(ex_alu_op), 0);
        chk({tag, "_mem_write"}, int'(mem_mem_write), 0);
        chk({tag, "_mem_read"}, int'(mem_mem_read), 0);
        chk({tag, "_wb_reg_write"}, int'(wb_reg_write), 0);
        chk({tag, "_wb_mem_to_reg"}, int'(wb_mem_to_reg), 0);
        chk({tag, "_wb_dst"}, int'(wb_dst), 0);
        chk({tag, "_pc_write"}, int'(pc_write), 1);
        chk({tag, "_ifid_write"}, int'(ifid_write), 1);
        chk({tag, "_fwd_a"}, int'(fwd_a), 0);
        chk({tag, "_fwd_b"}, int'(fwd_b), 0);
    endtask

    initial begin
        // Power-on reset
        #2;
        chk_idle("rst0");
        chk("rst0_flush", int'(ifid_flush), 0);
        #20;
        rst_n = 1'b1;
        tick();

        // ADD rd=3 then SUB rs=3: EX/MEM forward
        drive(ADD, 1, 1, 2, 3);
        tick();
        chk("add_ex_reg_dest", int'(ex_reg_dest), 1);
        drive(SUB, 1, 3, 4, 6);
        tick();
        chk("sub_ex_alu_op", int'(ex_alu_op), 1);
        chk("fwd_mem_a", int'(fwd_a), 2);
        chk("fwd_mem_b", int'(fwd_b), 0);
        drain();

        // ADD rd=3, unrelated, SUB rs=3: MEM/WB forward
        drive(ADD, 1, 1, 2, 3); tick();
        drive(ADD, 1, 8, 9, 7); tick();
        drive(SUB, 1, 3, 4, 6); tick();
        chk("fwd_wb_a", int'(fwd_a), 1);
        chk("fwd_wb_b", int'(fwd_b), 0);
        chk("wb_dst_add", int'(wb_dst), 3);
        chk("wb_rw_add", int'(wb_reg_write), 1);
        drain();

        // Destination register 0 never forwards
        drive(ADD, 1, 1, 2, 0); tick();
        drive(SUB, 1, 0, 0, 6); tick();
        chk("fwd_r0_a", int'(fwd_a), 0);
        chk("fwd_r0_b", int'(fwd_b), 0);
        drain();

        // LW rt=5 then AND rt=5: one bubble, then WB forward
        drive(LW, 1, 1, 5, 0); tick();
        drive(AND, 1, 6, 5, 7);
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_ifid_write", int'(ifid_write), 0);
        chk("lu_flush", int'(ifid_flush), 0);
        chk("lu_ex_alu_src", int'(ex_alu_src), 1);
        tick();
        chk("lu_bub_alu_src", int'(ex_alu_src), 0);
        chk("lu_bub_reg_dest", int'(ex_reg_dest), 0);
        chk("lu_bub_alu_op", int'(ex_alu_op), 0);
        chk("lu_bub_pc_write", int'(pc_write), 1);
        chk("lu_mem_read", int'(mem_mem_read), 1);
        tick();
        chk("lu_and_alu_op", int'(ex_alu_op), 2);
        chk("lu_fwd_b", int'(fwd_b), 1);
        chk("lu_fwd_a", int'(fwd_a), 0);
        chk("lu_wb_m2r", int'(wb_mem_to_reg), 1);
        chk("lu_wb_dst", int'(wb_dst), 5);
        drain();

        // LW rt=5 then LW rs=4 rt=5: rt is not a source, no stall
        drive(LW, 1, 1, 5, 0); tick();
        drive(LW, 1, 4, 5, 0);
        chk("lwlw_pc_write", int'(pc_write), 1);
        chk("lwlw_ifid_write", int'(ifid_write), 1);
        drain();

        // Taken BNE in MEM overrides a simultaneous load-use stall
        drive(BNE, 1, 1, 2, 0); tick();
        drive(LW, 1, 1, 5, 0); tick();
        drive(AND, 1, 5, 6, 7);
        mem_ne = 1'b1;
        #1;
        chk("br_take", int'(branch_take), 1);
        chk("br_flush", int'(ifid_flush), 1);
        chk("br_pc_write", int'(pc_write), 1);
        chk("br_ifid_write", int'(ifid_write), 1);
        chk("br_jump", int'(jump_take), 0);
        tick();
        mem_ne = 1'b0;
        drive('0, 0, 0, 0, 0);
        chk("br_ex_alu_src", int'(ex_alu_src), 0);
        chk("br_ex_reg_dest", int'(ex_reg_dest), 0);
        chk("br_ex_alu_op", int'(ex_alu_op), 0);
        chk("br_mem_read", int'(mem_mem_read), 0);
        chk("br_mem_write", int'(mem_mem_write), 0);
        chk("br_wb_rw", int'(wb_reg_write), 0);
        drain();

        // Same sequence, BNE not taken: stall proceeds normally
        drive(BNE, 1, 1, 2, 0); tick();
        drive(LW, 1, 1, 5, 0); tick();
        drive(AND, 1, 5, 6, 7);
        chk("nbr_take", int'(branch_take), 0);
        chk("nbr_flush", int'(ifid_flush), 0);
        chk("nbr_pc_write", int'(pc_write), 0);
        tick();
        chk("nbr_mem_read", int'(mem_mem_read), 1);
        chk("nbr_ex_bubble", int'(ex_alu_src), 0);
        drain();

        // Jump: one-cycle take and flush, retires with no register write
        drive(JMP, 1, 0, 0, 0);
        chk("jmp_take", int'(jump_take), 1);
        chk("jmp_flush", int'(ifid_flush), 1);
        chk("jmp_pc_write", int'(pc_write), 1);
        tick();
        drive('0, 0, 0, 0, 0);
        chk("jmp_take_off", int'(jump_take), 0);
        chk("jmp_flush_off", int'(ifid_flush), 0);
        tick(); tick();
        chk("jmp_wb_rw", int'(wb_reg_write), 0);
        drive(JMP, 0, 0, 0, 0);
        chk("jmp_inv_take", int'(jump_take), 0);
        chk("jmp_inv_flush", int'(ifid_flush), 0);
        drain();

        // Async reset in the middle of a load-use stall
        drive(ADD, 1, 1, 2, 3); tick();
        drive(LW, 1, 1, 5, 0); tick();
        drive(AND, 1, 5, 6, 7);
        chk("prerst_pc_write", int'(pc_write), 0);
        drive('0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_idle("rst1");
        tick();
        #2;
        rst_n = 1'b1;
        drive(ADD, 1, 1, 2, 3);
        tick();
        chk("post_rst_reg_dest", int'(ex_reg_dest), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
